// File: rtl/dm_responder.sv
// Wait-state data-memory responder for the CPU MEM stage: latches a request,
// holds the pipeline for LAT cycles, then answers with a one-cycle ready pulse.
module dm_responder #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Mem_ID,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [31:0] Mem_WData,
  output logic [31:0] Mem_RData,
  output logic        Mem_Ready,
  output logic        Mem_Err,
  output logic        Mem_Stall
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [3:0]        counter;
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       lat_wdata;
  logic              lat_write;
  logic              lat_err;

  logic [31:0] DataMemory [0:2**ADDR_W-1];

  logic req;
  logic req_err;
  logic last_wait;
  logic commit;

  assign req       = Mem_Read | Mem_Write;
  assign req_err   = (Mem_ID[1:0] != 2'b00)
                   || ((Mem_ID >> (ADDR_W + 2)) != 32'd0)
                   || (Mem_Read & Mem_Write);
  assign last_wait = (state == WAIT) && (counter == 4'd1);
  assign commit    = last_wait && lat_write && !lat_err;

  // Stall is forced low while reset is held so the CPU sees a quiet port.
  assign Mem_Stall = reset && ((state == WAIT) || ((state == IDLE) && req));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= 4'd0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      Mem_RData <= 32'd0;
      Mem_Ready <= 1'b0;
      Mem_Err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_idx   <= Mem_ID[ADDR_W+1:2];
            lat_wdata <= Mem_WData;
            lat_write <= Mem_Write;
            lat_err   <= req_err;
            counter   <= 4'(LAT);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (counter == 4'd1) begin
            counter   <= 4'd0;
            state     <= RESP;
            Mem_Ready <= 1'b1;
            Mem_Err   <= lat_err;
            Mem_RData <= (lat_err || lat_write) ? 32'd0 : DataMemory[lat_idx];
          end else begin
            counter <= counter - 4'd1;
          end
        end
        RESP: begin
          Mem_Ready <= 1'b0;
          Mem_Err   <= 1'b0;
          Mem_RData <= 32'd0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The array has no reset; a reset during WAIT clears state, so no commit follows.
  always_ff @(posedge clk) begin
    if (commit) begin
      DataMemory[lat_idx] <= lat_wdata;
    end
  end

endmodule
